// File: rtl/esm_dep_tracker.sv
// Dependency tracker for an in-flight instruction window: free-list slot allocation,
// register-producer table, BSxBS dependency matrix, completion retire and ready flags.
module esm_dep_tracker #(
    parameter int INSTR_W   = 32,
    parameter int REGNUM    = 32,
    parameter int BS        = 16,
    parameter int TRACK_WAW = 0,
    localparam int RA = $clog2(REGNUM),
    localparam int SA = $clog2(BS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               alu_src,
    input  logic               reg_write,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SA-1:0]      alloc_idx,
    input  logic               comp_valid,
    input  logic [SA-1:0]      comp_idx,
    output logic [BS-1:0]      ready_positions,
    output logic [BS-1:0]      occupied,
    output logic               full,
    output logic               empty
);

    logic [BS-1:0]              occ_q, occ_d;
    logic [BS-1:0][BS-1:0]      dep_q, dep_d;
    logic [REGNUM-1:0]          pvalid_q, pvalid_d;
    logic [REGNUM-1:0][SA-1:0]  pslot_q, pslot_d;

    logic [RA-1:0]      rs1, rs2_eff, rd_eff;
    logic [2:0][RA-1:0] src;
    logic [BS-1:0]      new_row;
    logic               comp_ok, accept_new;

    assign rs1     = instr_in[15 +: RA];
    assign rs2_eff = alu_src   ? '0 : instr_in[20 +: RA];
    assign rd_eff  = reg_write ? instr_in[7 +: RA] : '0;

    assign full       = &occ_q;
    assign empty      = ~|occ_q;
    assign in_ready   = ~full;
    assign occupied   = occ_q;
    assign comp_ok    = comp_valid && occ_q[comp_idx];
    assign accept_new = in_valid && in_ready && (|instr_in);

    // Lowest free slot; scanning downward lets the smallest index win.
    always_comb begin
        alloc_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!occ_q[i]) alloc_idx = SA'(i);
        end
    end

    // Producer lookup on the pre-update table, with the completing slot bypassed.
    always_comb begin
        src[0] = rs1;
        src[1] = rs2_eff;
        src[2] = (TRACK_WAW != 0) ? rd_eff : '0;
        new_row = '0;
        for (int k = 0; k < 3; k++) begin
            if (src[k] != '0 && pvalid_q[src[k]] &&
                !(comp_ok && pslot_q[src[k]] == comp_idx))
                new_row[pslot_q[src[k]]] = 1'b1;
        end
    end

    always_comb begin
        occ_d    = occ_q;
        dep_d    = dep_q;
        pvalid_d = pvalid_q;
        pslot_d  = pslot_q;
        if (comp_ok) begin
            occ_d[comp_idx] = 1'b0;
            for (int r = 0; r < BS; r++) dep_d[r][comp_idx] = 1'b0;
            dep_d[comp_idx] = '0;
            for (int g = 0; g < REGNUM; g++) begin
                if (pvalid_q[g] && pslot_q[g] == comp_idx) pvalid_d[g] = 1'b0;
            end
        end
        // Applied after completion so a new producer of the same register wins.
        if (accept_new) begin
            occ_d[alloc_idx] = 1'b1;
            dep_d[alloc_idx] = new_row;
            if (rd_eff != '0) begin
                pvalid_d[rd_eff] = 1'b1;
                pslot_d[rd_eff]  = alloc_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q    <= '0;
            dep_q    <= '0;
            pvalid_q <= '0;
            pslot_q  <= '0;
        end else begin
            occ_q    <= occ_d;
            dep_q    <= dep_d;
            pvalid_q <= pvalid_d;
            pslot_q  <= pslot_d;
        end
    end

    always_comb begin
        ready_positions = '0;
        for (int i = 0; i < BS; i++) ready_positions[i] = occ_q[i] && ~|dep_q[i];
    end

endmodule

// File: doc/esm_dep_tracker.md
Name: esm_dep_tracker

Overview:
- Parametrised successor to the ESM dependency core.
- Tracks in-flight instructions in a BS-slot window and allocates slots internally from a free list, replacing the externally supplied buffer index.
- Records RAW dependencies, and optionally WAW, through a register-producer table and a BS x BS dependency matrix.
- Retires slots through a completion port and publishes per-slot ready flags to the downstream issue/dispatch stage.

Parameters:
INSTR_W 32 instruction word width
REGNUM 32 architectural register count; RA = $clog2(REGNUM)
BS 16 window depth in slots; SA = $clog2(BS)
TRACK_WAW 0 when 1, a new instruction also depends on the current producer of its rd

Ports:
clk input 1 clock, rising edge
rst input 1 reset, synchronous, active-low
instr_in input INSTR_W instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7]
alu_src input 1 1: rs2 unused
reg_write input 1 1: rd written
in_valid input 1 instruction offered
in_ready output 1 window can accept
alloc_idx output SA slot the offered instruction will occupy
comp_valid input 1 completion strobe
comp_idx input SA slot completing
ready_positions output BS slot occupied and has no outstanding dependency
occupied output BS slot holds a live instruction
full output 1 all slots occupied
empty output 1 no slot occupied

Behaviour:
- Reset (rst=0 at a clk edge), including mid-operation:
  - occupied, dep matrix and producer valid bits all clear; the window is discarded.
  - Outputs: ready_positions=0, full=0, empty=1, in_ready=1, alloc_idx=0.
- Decode:
  - rs2_eff = alu_src ? 0 : rs2.
  - rd_eff = reg_write ? rd : 0.
  - Register 0 is never tracked, either as a source or as a producer.
- Handshake:
  - in_ready = !full.
  - Accept = in_valid && in_ready.
  - in_valid while full is held off with no state change.
- Allocation: alloc_idx = lowest index with occupied=0, computed combinationally from registered occupied. It is don't-care when full.
- Null instruction (instr_in all zero): the handshake completes but nothing is allocated and no state changes.
- On accept of a non-null instruction, at the next edge:
  - occupied[alloc_idx] <= 1.
  - dep row alloc_idx <= one-hot producer slot of rs1 (if tracked) OR that of rs2_eff (if tracked). When rs1==rs2, a single bit is set.
  - If TRACK_WAW, the row also ORs in the producer slot of rd_eff.
  - If rd_eff != 0: pvalid[rd_eff] <= 1 and pslot[rd_eff] <= alloc_idx.
  - Source lookup uses the pre-update table, so an instruction with rd == rs1 depends on the previous producer, never on itself.
- Completion (comp_valid=1), at the next edge:
  - occupied[comp_idx] <= 0.
  - Column comp_idx is cleared in every dep row; the comp_idx row is cleared.
  - Every register with pvalid && pslot==comp_idx gets pvalid <= 0.
  - Completion of an unoccupied slot is ignored; no state changes.
- Simultaneous accept and completion:
  - Completion is bypassed into the lookup: a source whose producer is comp_idx records no dependency.
  - The freed slot is not reallocated in the same cycle.
  - If the new rd_eff equals a register whose pvalid is being cleared, the new producer wins (pvalid=1, pslot=alloc_idx).
- Outputs:
  - ready_positions[i] = occupied[i] && ~|dep[i], combinational from registers.
  - A new instruction therefore appears in ready_positions one cycle after accept.
  - A dependent slot becomes ready one cycle after the completion edge of its last producer.
  - full = &occupied, empty = ~|occupied.

Test Plan:
- Reset then idle, rst=0 for 2 cycles -> ready_positions=0, empty=1, full=0, in_ready=1, alloc_idx=0.
- Accept add x3,x1,x2 then add x4,x3,x0:
  - Slots 0 and 1 are used.
  - ready_positions=0b01 one cycle after the second accept.
  - comp_idx=0 -> ready_positions=0b10 the next cycle.
- Accept 16 non-null instructions with no register overlap:
  - full=1 and in_ready=0; a 17th in_valid is held off.
  - comp_idx=5 -> full=0 and alloc_idx=5 the following cycle.
- Same cycle: comp_idx=0 (producer of x3) and accept of sub x6,x3,x3 -> new slot 1 has no dependency; ready_positions[1]=1 next cycle.
- TRACK_WAW=1:
  - Accept lw x7 (slot 0), then addi x7,x1,4 with alu_src=1 (slot 1).
  - Slot 1 is not ready until comp_idx=0.
  - With TRACK_WAW=0, slot 1 is ready immediately.
- Null instruction and invalid completion:
  - instr_in=0 accepted -> occupied unchanged.
  - comp_idx=9 with slot 9 empty -> no change.
  - rst=0 mid-window -> all outputs return to reset values.
